mips_multicycle_ctrl: RTL and testbench

Multicycle control unit for the MIPS datapath. It sequences the flip-flop-based PC, IR, register file and ALU through fetch/decode/execute/memory/writeback steps, one instruction at a time. It issues per-cycle enables and mux selects, and stalls on a memory ready handshake. It sits between the instruction register's opcode field and every datapath enable.

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/mips_ctrl_decode.sv | 96 +++++++++
 rtl/mips_multicycle_ctrl.sv | 92 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes and datapath mux selects.
// MIPS_CTRL_JUMP_EN adds the JUMP state and makes opcode 000010 legal.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
`ifdef MIPS_CTRL_JUMP_EN
    ,
    S_JUMP   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: Moore outputs from state, plus FETCH handshake and BEQ zero terms.
// Zero latency; memory stalls are handled by the state register holding FETCH/MEMRD/MEMWR.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_en,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src
);

  logic pc_write;
  logic branch;

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        // IR and PC only load on the cycle the fetch actually completes
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register and next-state logic; one instruction at a time.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; MIPS_CTRL_JUMP_EN enables the j instruction.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_IDLE;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

  mips_ctrl_decode u_decode (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_en      (pc_en),
    .ior_d      (ior_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table with a scoreboard of expected state/controls.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

`ifdef MIPS_CTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, BAD = 6'b111111;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic       seg;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        seg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seg_mem_write = 0;
  int   seg_reg_write = 0;

  // Order: pc_en ior_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write src_a srcb aluop pcsrc illegal
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                           input logic [5:0] op);
    logic pe, io, mrd, mwr, irw, rd, m2r, rw, sa, ill;
    logic [1:0] sb_, ao, ps;
    {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, ill} = '0;
    sb_ = 2'd0; ao = 2'd0; ps = 2'd0;
    case (st)
      4'd1:  begin mrd = 1'b1; sb_ = 2'd1; irw = mr; pe = mr; end
      4'd2:  begin
        sb_ = 2'd3;
        ill = !(op == LW || op == SW || op == R || op == BQ || op == AI || (JEN && op == JJ));
      end
      4'd3:  begin sa = 1'b1; sb_ = 2'd2; end
      4'd4:  begin io = 1'b1; mrd = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin io = 1'b1; mwr = 1'b1; end
      4'd7:  begin sa = 1'b1; ao = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin sa = 1'b1; ao = 2'b01; ps = 2'd1; pe = z; end
      4'd10: begin sa = 1'b1; sb_ = 2'd2; end
      4'd11: begin rw = 1'b1; end
      4'd12: begin pe = 1'b1; ps = 2'd2; end
      default: ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb_, ao, ps, ill};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic seg);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.st = st; v.seg = seg;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = v.rst; opcode = v.op; zero = v.z; mem_ready = v.mr;
    e.st = v.st;
    e.ctrl = exp_ctrl(v.st, v.mr, v.z, v.op);
    e.seg = v.seg;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", {12'd0, state}, {12'd0, e.st});
      check("ctrl", {pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}, e.ctrl);
      if (e.seg) begin
        seg_mem_write += int'(mem_write);
        seg_reg_write += int'(reg_write);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // reset, then R-type: 0,1,2,7,8,1 (zero high to show it is ignored outside BEQ)
    add(0, R, 0, 1, 4'd0, 0);
    add(1, R, 0, 1, 4'd0, 0);
    add(1, R, 1, 1, 4'd1, 0);
    add(1, R, 1, 1, 4'd2, 0);
    add(1, R, 1, 1, 4'd7, 0);
    add(1, R, 1, 1, 4'd8, 0);
    // lw with two MEMRD wait cycles: 7 cycles FETCH to FETCH
    add(1, LW, 0, 1, 4'd1, 0);
    add(1, LW, 0, 1, 4'd2, 0);
    add(1, LW, 0, 1, 4'd3, 0);
    add(1, LW, 0, 0, 4'd4, 0);
    add(1, LW, 0, 0, 4'd4, 0);
    add(1, LW, 0, 1, 4'd4, 0);
    add(1, LW, 0, 1, 4'd5, 0);
    // beq taken, then not taken
    add(1, BQ, 1, 1, 4'd1, 0);
    add(1, BQ, 1, 1, 4'd2, 0);
    add(1, BQ, 1, 1, 4'd9, 0);
    add(1, BQ, 0, 1, 4'd1, 0);
    add(1, BQ, 0, 1, 4'd2, 0);
    add(1, BQ, 0, 1, 4'd9, 0);
    // fetch stall, then illegal opcode
    add(1, BAD, 0, 0, 4'd1, 0);
    add(1, BAD, 0, 0, 4'd1, 0);
    add(1, BAD, 0, 1, 4'd1, 0);
    add(1, BAD, 0, 1, 4'd2, 0);
    // j: JUMP when enabled, illegal otherwise
    add(1, JJ, 0, 1, 4'd1, 0);
    add(1, JJ, 0, 1, 4'd2, 0);
    if (JEN) add(1, JJ, 0, 1, 4'd12, 0);
    // back-to-back sw then addi
    add(1, SW, 0, 1, 4'd1, 1);
    add(1, SW, 0, 1, 4'd2, 1);
    add(1, SW, 0, 1, 4'd3, 1);
    add(1, SW, 0, 1, 4'd6, 1);
    add(1, AI, 0, 1, 4'd1, 1);
    add(1, AI, 0, 1, 4'd2, 1);
    add(1, AI, 0, 1, 4'd10, 1);
    add(1, AI, 0, 1, 4'd11, 1);
    // sw that stalls in MEMWR, aborted by reset below
    add(1, SW, 0, 1, 4'd1, 0);
    add(1, SW, 0, 1, 4'd2, 0);
    add(1, SW, 0, 1, 4'd3, 0);
    add(1, SW, 0, 0, 4'd6, 0);
    add(1, SW, 0, 0, 4'd6, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    @(negedge clk);
    #1;

    check("seg_mem_write_cycles", 16'(seg_mem_write), 16'd1);
    check("seg_reg_write_cycles", 16'(seg_reg_write), 16'd1);

    check("memwr_before_reset", {15'd0, mem_write}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("memwr_async_reset", {15'd0, mem_write}, 16'd0);
    check("state_async_reset", {12'd0, state}, 16'd0);

    v.rst = 1; v.op = R; v.z = 0; v.mr = 1; v.seg = 0;
    v.st = 4'd0; step(v);
    v.st = 4'd1; step(v);
    v.st = 4'd2; step(v);
    v.st = 4'd7; step(v);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
